xoodyak_absorb_packer: RTL
==========================

Name: xoodyak_absorb_packer

Overview:
- Parametrised, length-driven message ingest front end for the Xoodyak hash datapath.
- Accepts message bytes IN_BYTES per beat over a valid/ready handshake and packs them into rate-sized absorb blocks, zero-filled past the data.
- Emits one block at a time to the permutation/absorb controller, with the block length and first/last flags.
- Successor to the byte-serial msg/msg_len/start interface: configurable input width, rate and length width, plus back-pressure on both sides.

Parameters:
- RATE_BYTES, 16: absorb block size in bytes (Xoodyak Rhash); must be a multiple of IN_BYTES.
- IN_BYTES, 1: message bytes per input beat; legal values 1, 2, 4.
- LEN_W, 12: width of the message length in bytes.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a message; ignored unless idle.
- msg_len  in  LEN_W  message length in bytes; sampled when start is accepted.
- in_data  in  8*IN_BYTES  message bytes; lane 0 (bits 7:0) is the earliest byte.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  packer accepts a beat this cycle.
- blk_data  out  8*RATE_BYTES  block; byte i at bits 8i+7:8i; bytes at index ≥ blk_len are 0.
- blk_len  out  $clog2(RATE_BYTES+1)  valid data bytes in the block, 0..RATE_BYTES.
- blk_first  out  1  block is the first block of the message.
- blk_last  out  1  block is the last block of the message.
- blk_valid  out  1  block outputs are stable and valid.
- blk_ready  in  1  consumer takes the block.
- busy  out  1  high from start acceptance until the last block is handed off.

Behaviour:
- Reset (asynchronous, active-high): state IDLE; in_ready=0, blk_valid=0, busy=0, blk_data=0, blk_len=0, blk_first=0, blk_last=0; internal counters cleared.
  - Reset mid-message aborts the message. No partial block is emitted after reset.
- States: IDLE, FILL, EMIT.
- IDLE:
  - start=1: latch rem=msg_len; set first_pending=1 and busy=1; clear the block buffer.
  - If msg_len=0, go to EMIT with blk_len=0, first=last=1. Otherwise go to FILL.
  - start in any other state is ignored.
- FILL:
  - in_ready=1. A beat transfers when in_valid && in_ready.
  - Lanes are written at byte offset fill_cnt.
  - take = min(IN_BYTES, rem); lanes ≥ take are discarded, and those buffer bytes stay 0.
  - rem -= take; fill_cnt += take.
  - When fill_cnt reaches RATE_BYTES or rem reaches 0, go to EMIT on the next cycle.
    - blk_len = fill_cnt.
    - blk_first = first_pending.
    - blk_last = (rem==0).
- EMIT:
  - in_ready=0; blk_valid=1.
  - blk_data, blk_len and the flags are held constant until the handshake.
  - On blk_valid && blk_ready:
    - Clear the buffer, fill_cnt and first_pending.
    - If the block was last: go to IDLE and drop busy in the same edge.
    - Otherwise: return to FILL.
  - Minimum gap between blocks is one cycle. There is no double buffering.
- Block count is max(1, ceil(msg_len/RATE_BYTES)). A message of exactly k*RATE_BYTES bytes gives k full blocks and no extra block. The pad byte 0x01 at offset blk_len is applied downstream.
- in_valid while in_ready=0 is ignored; in_data need not be held.
- start and a block handshake in the same cycle while in EMIT (last): the start is ignored because the state is not yet IDLE.
- Max length 2^LEN_W−1. The counters must not overflow; rem is LEN_W bits.

Decomposition:
- Shared package xoodyak_pkg holds:
  - the state enum (IDLE/FILL/EMIT);
  - XOODYAK_RHASH=16 and XOODYAK_PAD_BYTE=8'h01;
  - the block length width function.
- One natural sub-module: xoodyak_lane_writer, a combinational byte-lane merge of in_data into the block buffer at offset fill_cnt with a take mask. It is reused by the future keyed-mode packer.

Test Plan:
- IN_BYTES=1, msg_len=0, start.
  - Required: one block, blk_len=0, blk_data all 0, first=last=1.
  - busy falls on the handshake edge.
- IN_BYTES=1, msg_len=3, bytes 0xAA,0xBB,0xCC.
  - Required: blk_data[23:0]=0xCCBBAA, rest 0, blk_len=3, first=last=1.
- IN_BYTES=4, msg_len=16, four beats 0x03020100..0x0F0E0D0C.
  - Required: a single block, bytes 0x00..0x0F in order, blk_len=16, first=last=1; no second block.
- IN_BYTES=4, msg_len=21, six beats, blk_ready held low for 5 cycles on the first block.
  - First block: len 16, first=1, last=0, stable while stalled, in_ready=0 throughout the stall.
  - Second block: len 5, first=0, last=1; the upper 3 lanes of the final beat are discarded.
- Mid-FILL reset: assert reset after 2 beats of a 10-byte message.
  - Required: immediate in_ready=0, blk_valid=0, busy=0.
  - A new start with msg_len=1 then yields one clean block with len 1.
- start pulsed during FILL and during EMIT.
  - Required: no effect on rem, block contents or state sequence.

Source files
------------

// File: rtl/xoodyak_pkg.sv
// Shared definitions for the Xoodyak message ingest path: state encoding,
// hash-mode rate constants and the block length width helper.
package xoodyak_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_EMIT = 2'd2
    } state_e;

    localparam int         XOODYAK_RHASH    = 16;
    localparam logic [7:0] XOODYAK_PAD_BYTE = 8'h01;

    // Bits needed to hold a byte count from 0 to rate_bytes inclusive.
    function automatic int blk_len_w(input int rate_bytes);
        return $clog2(rate_bytes + 1);
    endfunction

endpackage

// File: rtl/xoodyak_lane_writer.sv
// Combinational merge of an input beat into a block buffer: lane j lands at
// byte offset_i + j when j < take_i; every other buffer byte passes through.
module xoodyak_lane_writer
    import xoodyak_pkg::*;
#(
    parameter int  RATE_BYTES = XOODYAK_RHASH,
    parameter int  IN_BYTES   = 1,
    localparam int BLW        = blk_len_w(RATE_BYTES)
) (
    input  logic [8*RATE_BYTES-1:0] buf_i,
    input  logic [8*IN_BYTES-1:0]   data_i,
    input  logic [BLW-1:0]          offset_i,
    input  logic [BLW-1:0]          take_i,
    output logic [8*RATE_BYTES-1:0] merged_o
);

    // Byte-wise select between the existing buffer byte and a taken lane.
    always_comb begin
        merged_o = buf_i;
        for (int i = 0; i < RATE_BYTES; i++) begin
            for (int j = 0; j < IN_BYTES; j++) begin
                merged_o[8*i +: 8] = ((int'(offset_i) + j == i) && (j < int'(take_i)))
                                     ? data_i[8*j +: 8] : merged_o[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/xoodyak_absorb_packer.sv
// Length-driven packer: gathers IN_BYTES-wide message beats into zero-filled
// rate-sized absorb blocks and hands them off one at a time with first/last flags.
module xoodyak_absorb_packer
    import xoodyak_pkg::*;
#(
    parameter int  RATE_BYTES = XOODYAK_RHASH,
    parameter int  IN_BYTES   = 1,
    parameter int  LEN_W      = 12,
    localparam int BLW        = blk_len_w(RATE_BYTES)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [LEN_W-1:0]        msg_len,
    input  logic [8*IN_BYTES-1:0]   in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [8*RATE_BYTES-1:0] blk_data,
    output logic [BLW-1:0]          blk_len,
    output logic                    blk_first,
    output logic                    blk_last,
    output logic                    blk_valid,
    input  logic                    blk_ready,
    output logic                    busy
);

    state_e                  state_q;
    logic [LEN_W-1:0]        rem_q;
    logic [BLW-1:0]          fill_q;
    logic                    first_pending_q;
    logic [8*RATE_BYTES-1:0] buf_q;
    logic                    in_ready_q;
    logic                    blk_valid_q;
    logic [BLW-1:0]          blk_len_q;
    logic                    blk_first_q;
    logic                    blk_last_q;
    logic                    busy_q;

    logic [BLW-1:0]          take_d;
    logic [LEN_W-1:0]        rem_d;
    logic [BLW-1:0]          fill_d;
    logic [8*RATE_BYTES-1:0] buf_d;
    logic                    blk_done_s;

    xoodyak_lane_writer #(
        .RATE_BYTES (RATE_BYTES),
        .IN_BYTES   (IN_BYTES)
    ) u_lane_writer (
        .buf_i    (buf_q),
        .data_i   (in_data),
        .offset_i (fill_q),
        .take_i   (take_d),
        .merged_o (buf_d)
    );

    // Beat bookkeeping: the final beat may carry fewer valid lanes than IN_BYTES.
    always_comb begin
        if (rem_q < LEN_W'(IN_BYTES)) begin
            take_d = BLW'(rem_q);
        end else begin
            take_d = BLW'(IN_BYTES);
        end
        rem_d      = rem_q - LEN_W'(take_d);
        fill_d     = fill_q + take_d;
        blk_done_s = (fill_d == BLW'(RATE_BYTES)) || (rem_d == {LEN_W{1'b0}});
    end

    // Packer FSM with registered handshake and block outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            rem_q           <= {LEN_W{1'b0}};
            fill_q          <= {BLW{1'b0}};
            first_pending_q <= 1'b0;
            buf_q           <= {(8*RATE_BYTES){1'b0}};
            in_ready_q      <= 1'b0;
            blk_valid_q     <= 1'b0;
            blk_len_q       <= {BLW{1'b0}};
            blk_first_q     <= 1'b0;
            blk_last_q      <= 1'b0;
            busy_q          <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        rem_q           <= msg_len;
                        fill_q          <= {BLW{1'b0}};
                        first_pending_q <= 1'b1;
                        buf_q           <= {(8*RATE_BYTES){1'b0}};
                        busy_q          <= 1'b1;
                        if (msg_len == {LEN_W{1'b0}}) begin
                            state_q     <= ST_EMIT;
                            blk_valid_q <= 1'b1;
                            blk_len_q   <= {BLW{1'b0}};
                            blk_first_q <= 1'b1;
                            blk_last_q  <= 1'b1;
                        end else begin
                            state_q    <= ST_FILL;
                            in_ready_q <= 1'b1;
                        end
                    end
                end
                ST_FILL: begin
                    if (in_valid && in_ready_q) begin
                        buf_q  <= buf_d;
                        rem_q  <= rem_d;
                        fill_q <= fill_d;
                        if (blk_done_s) begin
                            state_q     <= ST_EMIT;
                            in_ready_q  <= 1'b0;
                            blk_valid_q <= 1'b1;
                            blk_len_q   <= fill_d;
                            blk_first_q <= first_pending_q;
                            blk_last_q  <= (rem_d == {LEN_W{1'b0}});
                        end
                    end
                end
                ST_EMIT: begin
                    if (blk_ready) begin
                        buf_q           <= {(8*RATE_BYTES){1'b0}};
                        fill_q          <= {BLW{1'b0}};
                        first_pending_q <= 1'b0;
                        blk_valid_q     <= 1'b0;
                        if (blk_last_q) begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q    <= ST_FILL;
                            in_ready_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    in_ready_q  <= 1'b0;
                    blk_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign blk_data  = buf_q;
    assign blk_len   = blk_len_q;
    assign blk_first = blk_first_q;
    assign blk_last  = blk_last_q;
    assign blk_valid = blk_valid_q;
    assign busy      = busy_q;

endmodule
